// File: rtl/nv_nvdla_sdp_brs_operand_join.sv
// Joins the ALU and MUL operand streams into one registered BN operand stream,
// with a 2-entry skid FIFO per input, per-layer beat counting and last-mismatch detection.
module nv_nvdla_sdp_brs_operand_join (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         op_load,
    input  logic [1:0]   reg2dp_nrdma_data_use,
    input  logic         sdp_nrdma2dp_alu_valid,
    output logic         sdp_nrdma2dp_alu_ready,
    input  logic [256:0] sdp_nrdma2dp_alu_pd,
    input  logic         sdp_nrdma2dp_mul_valid,
    output logic         sdp_nrdma2dp_mul_ready,
    input  logic [256:0] sdp_nrdma2dp_mul_pd,
    output logic         brs_op_valid,
    input  logic         brs_op_ready,
    output logic [512:0] brs_op_pd,
    output logic         layer_done,
    output logic [31:0]  dp2reg_brs_beats,
    output logic         dp2reg_brs_last_err
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e       state_q, state_d;
    logic [1:0]   use_q, use_d;
    logic [31:0]  beats_q, beats_d;
    logic         err_q, err_d;
    logic         done_q, done_d;
    logic         out_valid_q;
    logic [512:0] out_pd_q;

    // Stream index 0 = ALU, 1 = MUL
    logic [256:0] mem_q [2][2];
    logic [1:0]   cnt_q [2];
    logic [1:0]   wp_q, rp_q;
    logic [1:0]   in_valid, in_ready, used, have, push, pop;
    logic [256:0] in_pd [2];
    logic [256:0] head [2];
    logic         out_fire, join_fire, join_last;

    assign in_valid = {sdp_nrdma2dp_mul_valid, sdp_nrdma2dp_alu_valid};
    assign in_pd[0] = sdp_nrdma2dp_alu_pd;
    assign in_pd[1] = sdp_nrdma2dp_mul_pd;
    assign used[0]  = (use_q == 2'd1) || (use_q == 2'd2);
    assign used[1]  = (use_q == 2'd0) || (use_q == 2'd2);

    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            in_ready[s] = (state_q == RUN) && used[s] && (cnt_q[s] != 2'd2);
            have[s]     = !used[s] || (cnt_q[s] != 2'd0);
            head[s]     = mem_q[s][rp_q[s]];
        end
    end

    assign push      = in_valid & in_ready;
    assign out_fire  = out_valid_q && brs_op_ready;
    // No join on the cycle the final beat leaves: remaining FIFO entries belong to the next layer
    assign join_fire = (state_q == RUN) && (&have) && (!out_valid_q || brs_op_ready)
                       && !(out_fire && out_pd_q[512]);
    assign pop       = join_fire ? used : 2'b00;
    assign join_last = |(used & {head[1][256], head[0][256]});

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (push[s]) wp_q[s] <= ~wp_q[s];
                if (pop[s])  rp_q[s] <= ~rp_q[s];
                cnt_q[s] <= cnt_q[s] + {1'b0, push[s]} - {1'b0, pop[s]};
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        for (int unsigned s = 0; s < 2; s++) begin
            if (push[s]) mem_q[s][wp_q[s]] <= in_pd[s];
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_valid_q <= 1'b0;
            out_pd_q    <= '0;
        end else if (join_fire) begin
            out_valid_q <= 1'b1;
            out_pd_q    <= {join_last,
                            used[1] ? head[1][255:0] : 256'd0,
                            used[0] ? head[0][255:0] : 256'd0};
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        use_d   = use_q;
        beats_d = beats_q;
        err_d   = err_q;
        done_d  = out_fire && out_pd_q[512];
        case (state_q)
            IDLE: begin
                if (op_load) begin
                    state_d = RUN;
                    use_d   = (reg2dp_nrdma_data_use == 2'd3) ? 2'd2 : reg2dp_nrdma_data_use;
                    beats_d = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (out_fire && out_pd_q[512]) state_d = IDLE;
                if (out_fire && (beats_q != '1)) beats_d = beats_q + 32'd1;
                if (join_fire && (&used) && (head[0][256] != head[1][256])) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= IDLE;
            use_q   <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            use_q   <= use_d;
            beats_q <= beats_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign sdp_nrdma2dp_alu_ready = in_ready[0];
    assign sdp_nrdma2dp_mul_ready = in_ready[1];
    assign brs_op_valid           = out_valid_q;
    assign brs_op_pd              = out_pd_q;
    assign layer_done             = done_q;
    assign dp2reg_brs_beats       = beats_q;
    assign dp2reg_brs_last_err    = err_q;

endmodule
